// File: rtl/prirv32_lsu.sv
// prirv32_lsu: one-transaction load/store unit with lane formatting, misalign and bus-timeout errors
module prirv32_lsu #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [7:0]  ld_st_sel,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_err,
  output logic [1:0]  lsu_err_cause,
  output logic [31:0] lsu_err_addr
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state_d, state_q;
  logic ld_q, uns_q, wb_valid_q, err_q;
  logic [1:0] size_q, cause_q;
  logic [31:0] addr_q, wdata_q, wb_data_q, err_addr_q;
  logic [4:0] rd_q, wb_rd_q;
  logic [3:0] wstrb_q;
  logic [7:0] cnt_q;
  logic [3:0] code;
  logic accept, mis, done, timeout;
  logic [31:0] st_wdata, lane_b, ld_data;
  logic [15:0] lane_h;
  logic [3:0] st_wstrb;
  // code = {is_load, unsigned, size}; MSB of ld_st_sel has priority
  assign code = ld_st_sel[7] ? 4'b1000 : ld_st_sel[6] ? 4'b1001 : ld_st_sel[5] ? 4'b1010 :
                ld_st_sel[4] ? 4'b1100 : ld_st_sel[3] ? 4'b1101 : ld_st_sel[2] ? 4'b0000 :
                ld_st_sel[1] ? 4'b0001 : 4'b0010;
  assign accept = lsu_valid && state_q == IDLE && |ld_st_sel;
  assign mis = code[1:0] == 2'd2 ? |addr_in[1:0] : code[1:0] == 2'd1 ? addr_in[0] : 1'b0;
  assign done = state_q == BUS && mem_ready;
  assign timeout = state_q == BUS && !mem_ready && cnt_q == 8'(MEM_TIMEOUT - 1);
  assign st_wdata = code[1:0] == 2'd0 ? {4{store_data_in[7:0]}} :
                    code[1:0] == 2'd1 ? {2{store_data_in[15:0]}} : store_data_in;
  assign st_wstrb = code[3] ? 4'b0000 : code[1:0] == 2'd0 ? 4'b0001 << addr_in[1:0] :
                    code[1:0] == 2'd1 ? 4'b0011 << {addr_in[1], 1'b0} : 4'b1111;
  assign lane_b = mem_rdata >> {addr_q[1:0], 3'b000};
  assign lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ld_data = size_q == 2'd2 ? mem_rdata :
                   size_q == 2'd1 ? {{16{~uns_q & lane_h[15]}}, lane_h} :
                   {{24{~uns_q & lane_b[7]}}, lane_b[7:0]};
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = accept ? (mis ? DONE : BUS) : IDLE;
      BUS:  state_d = (mem_ready || timeout) ? DONE : BUS;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ld_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= 2'd0;
      addr_q <= '0;
      rd_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q <= '0;
      wb_valid_q <= 1'b0;
      err_q <= 1'b0;
      cause_q <= 2'd0;
      err_addr_q <= '0;
      wb_data_q <= '0;
      wb_rd_q <= '0;
    end else begin
      state_q <= state_d;
      wb_valid_q <= done && ld_q && |rd_q;
      err_q <= (accept && mis) || timeout;
      if (state_q == BUS && !mem_ready) cnt_q <= cnt_q + 8'd1;
      if (accept) begin
        ld_q <= code[3];
        uns_q <= code[2];
        size_q <= code[1:0];
        addr_q <= addr_in;
        rd_q <= rd_in;
        wdata_q <= st_wdata;
        wstrb_q <= st_wstrb;
        cnt_q <= '0;
      end
      if (accept && mis) begin
        cause_q <= code[3] ? 2'b01 : 2'b10;
        err_addr_q <= addr_in;
      end
      if (timeout) begin
        cause_q <= 2'b11;
        err_addr_q <= addr_q;
      end
      if (done && ld_q) begin
        wb_data_q <= ld_data;
        wb_rd_q <= rd_q;
      end
    end
  end
  assign lsu_ready = state_q == IDLE;
  assign mem_valid = state_q == BUS;
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd = wb_rd_q;
  assign wb_data = wb_data_q;
  assign lsu_err = err_q;
  assign lsu_err_cause = cause_q;
  assign lsu_err_addr = err_addr_q;
endmodule

// File: tb/tb_prirv32_lsu.sv
// tb_prirv32_lsu: directed scoreboard bench for the load/store unit
module tb_prirv32_lsu;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic lsu_valid = 1'b0, lsu_ready, mem_valid, mem_ready = 1'b0, wb_valid, lsu_err;
  logic [7:0] ld_st_sel = '0;
  logic [31:0] addr_in = '0, store_data_in = '0, mem_addr, mem_wdata, mem_rdata = '0, wb_data, lsu_err_addr;
  logic [4:0] rd_in = '0, wb_rd;
  logic [3:0] mem_wstrb;
  logic [1:0] lsu_err_cause;
  int checks = 0, errors = 0, mv_cycles = 0;

  localparam int K_NONE = 0, K_BUS = 1, K_WB = 2, K_ERR = 3;
  localparam logic [7:0] LB = 8'h80, LH = 8'h40, LW = 8'h20, LBU = 8'h10, LHU = 8'h08, SB = 8'h04, SH = 8'h02, SW = 8'h01;
  typedef struct {int kind; logic [31:0] a; logic [31:0] d; logic [3:0] s; bit chkd;} exp_t;
  exp_t q[$];

  prirv32_lsu #(.MEM_TIMEOUT(64)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .ld_st_sel(ld_st_sel), .addr_in(addr_in), .store_data_in(store_data_in), .rd_in(rd_in),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .lsu_err(lsu_err), .lsu_err_cause(lsu_err_cause), .lsu_err_addr(lsu_err_addr)
  );

  always #5 clk_in = ~clk_in;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void exp_bus(logic [31:0] a, logic [31:0] d, logic [3:0] s, bit chkd);
    q.push_back('{K_BUS, a, d, s, chkd});
  endfunction
  function automatic void exp_wb(logic [4:0] rd, logic [31:0] d);
    q.push_back('{K_WB, {27'd0, rd}, d, 4'd0, 1'b1});
  endfunction
  function automatic void exp_err(logic [1:0] c, logic [31:0] a);
    q.push_back('{K_ERR, a, {30'd0, c}, 4'd0, 1'b1});
  endfunction

  always @(negedge clk_in) if (mem_valid) mv_cycles++;

  // monitor: pops the oldest expectation whenever the DUT presents an event
  always @(negedge clk_in) if (rst_n) begin
    exp_t e;
    if (mem_valid && mem_ready) begin
      chk("bus_event", K_BUS, q.size() > 0 ? q[0].kind : K_NONE);
      if (q.size() > 0 && q[0].kind == K_BUS) begin
        e = q.pop_front();
        chk("mem_addr", mem_addr, e.a);
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.s});
        if (e.chkd) chk("mem_wdata", mem_wdata, e.d);
      end
    end
    if (wb_valid) begin
      chk("wb_event", K_WB, q.size() > 0 ? q[0].kind : K_NONE);
      if (q.size() > 0 && q[0].kind == K_WB) begin
        e = q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, e.a);
        chk("wb_data", wb_data, e.d);
      end
    end
    if (lsu_err) begin
      chk("err_event", K_ERR, q.size() > 0 ? q[0].kind : K_NONE);
      if (q.size() > 0 && q[0].kind == K_ERR) begin
        e = q.pop_front();
        chk("err_cause", {30'd0, lsu_err_cause}, e.d);
        chk("err_addr", lsu_err_addr, e.a);
      end
    end
  end

  task automatic issue(input logic [7:0] sel, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    @(posedge clk_in); #1;
    chk("ready_before_op", {31'd0, lsu_ready}, 32'd1);
    lsu_valid = 1'b1; ld_st_sel = sel; addr_in = a; store_data_in = sd; rd_in = rd;
    @(posedge clk_in); #1;
    lsu_valid = 1'b0; ld_st_sel = '0;
  endtask

  task automatic run(input logic [7:0] sel, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                     input int waits, input logic [31:0] rdata, input bit aligned);
    int mv0;
    mv0 = mv_cycles;
    issue(sel, a, sd, rd);
    if (aligned) begin
      repeat (waits) begin
        @(posedge clk_in); #1;
      end
      mem_ready = 1'b1; mem_rdata = rdata;
      @(posedge clk_in); #1;
      mem_ready = 1'b0;
      chk("mv_cycles", mv_cycles - mv0, waits + 1);
      chk("wb_valid_timing", {31'd0, wb_valid}, {31'd0, (|sel[7:3]) && rd != 0});
    end else begin
      chk("mis_err_timing", {31'd0, lsu_err}, 32'd1);
    end
    @(posedge clk_in); #1;
    chk("ready_after_op", {31'd0, lsu_ready}, 32'd1);
    if (!aligned) chk("mis_no_bus", mv_cycles - mv0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mv0;
    bit got;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_err", {31'd0, lsu_err}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;

    exp_bus(32'h1000, 32'h0, 4'b0000, 1'b0); exp_wb(5'd5, 32'h0000_0080);
    run(LBU, 32'h1003, 32'h0, 5'd5, 0, 32'h80FF_1234, 1'b1);
    exp_bus(32'h1000, 32'h0, 4'b0000, 1'b0); exp_wb(5'd6, 32'hFFFF_FF80);
    run(LB, 32'h1003, 32'h0, 5'd6, 0, 32'h80FF_1234, 1'b1);
    exp_bus(32'h2000, 32'h5678_5678, 4'b1100, 1'b1);
    run(SH, 32'h2002, 32'hABCD_5678, 5'd1, 3, 32'h0, 1'b1);
    exp_err(2'b01, 32'h3001);
    run(LW, 32'h3001, 32'h0, 5'd2, 0, 32'h0, 1'b0);
    exp_err(2'b10, 32'h3003);
    run(SH, 32'h3003, 32'h0, 5'd2, 0, 32'h0, 1'b0);
    exp_bus(32'h5000, 32'h0, 4'b0000, 1'b0);
    run(LW, 32'h5000, 32'h0, 5'd0, 0, 32'h1234_5678, 1'b1);
    exp_bus(32'h6004, 32'h0, 4'b0000, 1'b0); exp_wb(5'd7, 32'hDEAD_BEEF);
    run(LW | SB, 32'h6004, 32'h0, 5'd7, 1, 32'hDEAD_BEEF, 1'b1);
    exp_bus(32'h7000, 32'h0, 4'b0000, 1'b0); exp_wb(5'd8, 32'hFFFF_8001);
    run(LH, 32'h7002, 32'h0, 5'd8, 0, 32'h8001_1234, 1'b1);
    exp_bus(32'h7000, 32'h0, 4'b0000, 1'b0); exp_wb(5'd9, 32'h0000_8001);
    run(LHU, 32'h7002, 32'h0, 5'd9, 2, 32'h8001_1234, 1'b1);
    exp_bus(32'h8000, 32'h4444_4444, 4'b0010, 1'b1);
    run(SB, 32'h8001, 32'h1122_3344, 5'd0, 0, 32'h0, 1'b1);

    lsu_valid = 1'b1; ld_st_sel = '0;
    repeat (3) begin
      @(posedge clk_in); #1;
      chk("zero_hot_ready", {31'd0, lsu_ready}, 32'd1);
      chk("zero_hot_no_bus", {31'd0, mem_valid}, 32'd0);
    end
    lsu_valid = 1'b0;

    exp_err(2'b11, 32'h4000);
    mv0 = mv_cycles;
    issue(LW, 32'h4000, 32'h0, 5'd3);
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk_in); #1;
      if (lsu_err) begin
        got = 1'b1;
        break;
      end
    end
    chk("timeout_seen", {31'd0, got}, 32'd1);
    chk("timeout_mv_cycles", mv_cycles - mv0, 64);
    @(posedge clk_in); #1;
    chk("timeout_ready", {31'd0, lsu_ready}, 32'd1);

    issue(LW, 32'h9000, 32'h0, 5'd4);
    repeat (2) @(posedge clk_in);
    #3;
    chk("pre_rst_mem_valid", {31'd0, mem_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("async_rst_wb", {31'd0, wb_valid}, 32'd0);
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    exp_bus(32'hA000, 32'hCAFE_F00D, 4'b1111, 1'b1);
    run(SW, 32'hA000, 32'hCAFE_F00D, 5'd0, 1, 32'h0, 1'b1);

    repeat (2) @(posedge clk_in);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prirv32_lsu.md
# prirv32_lsu

Load/store unit directly downstream of the execute stage. It takes the effective address computed by the EXU ALU (rs1 + imm), the store operand (rs2) and a one-hot load/store select, then runs one data-memory transaction over a valid/ready bus. It formats load data (lane select plus sign/zero extension) for register writeback. It reports misaligned accesses and bus timeouts as error pulses.

## Interface
Parameters:
- MEM_TIMEOUT, 64, cycles to wait for mem_ready before aborting with a bus-timeout error (legal 1..255)

Ports:
- clk_in  in  1  sole clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- lsu_valid  in  1  EXU presents a memory op
- lsu_ready  out  1  LSU idle, accepts op this cycle
- ld_st_sel  in  8  one-hot {lb, lh, lw, lbu, lhu, sb, sh, sw}, MSB first
- addr_in  in  32  effective address (EXU ALU output)
- store_data_in  in  32  rs2 value
- rd_in  in  5  load destination register
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completes request
- mem_addr  out  32  word address, {addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables; 0 for loads
- mem_rdata  in  32  read data, valid when mem_valid & mem_ready
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  5  writeback register
- wb_data  out  32  formatted load result
- lsu_err  out  1  one-cycle error pulse
- lsu_err_cause  out  2  01 load misaligned, 10 store misaligned, 11 bus timeout
- lsu_err_addr  out  32  faulting addr_in

## Operation
- Three states: IDLE, BUS, DONE.
- lsu_ready = 1 only in IDLE.
- Accept on the edge where lsu_valid & lsu_ready & |ld_st_sel.
  - Zero-hot ld_st_sel: request ignored, remains IDLE.
  - Multi-hot: lowest-index (MSB-first) bit wins.
- At accept, latch op, addr, rd and store data, then check alignment:
  - lh/lhu/sh: misaligned if addr[0]=1.
  - lw/sw: misaligned if addr[1:0]≠0.
  - lb/lbu/sb: never misaligned.
  - Misaligned: go to DONE with cause 01 (load) or 10 (store). No bus cycle is issued.
  - Aligned: go to BUS and clear the timeout counter.
- BUS: mem_valid=1. mem_addr, mem_wdata and mem_wstrb stay stable until completion.
  - mem_ready=1: capture mem_rdata (loads), go to DONE.
  - Otherwise the counter increments. When the counter reaches MEM_TIMEOUT-1 with no mem_ready, go to DONE with cause 11 and drop mem_valid.
- Store formatting:
  - sb: wdata = {4{b}}, wstrb = 0001 << addr[1:0].
  - sh: wdata = {2{h}}, wstrb = 0011 << {addr[1],1'b0}.
  - sw: wstrb = 1111.
- Load formatting:
  - Byte lane addr[1:0], halfword lane addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes rdata through.
- DONE (exactly one cycle), then return to IDLE:
  - Error: lsu_err=1, wb_valid=0.
  - Successful load with rd≠0: wb_valid=1.
  - Store, or load with rd=0: no pulse.
- Reset, asynchronous, also mid-transaction: state=IDLE, mem_valid drops immediately, all outputs 0 except lsu_ready=1, counter cleared. An aborted bus transaction is not replayed.

## Timing
- Aligned op accepted at edge E0:
  - mem_valid high from E0.
  - mem_ready sampled at edge E0+k (k≥1): wb_valid/lsu_err high for cycle after E0+k.
  - lsu_ready high again after E0+k+1.
- Zero-wait memory (mem_ready tied 1): accept-to-wb_valid = 2 cycles; throughput one op per 3 cycles.
- Misaligned: lsu_err in the cycle after accept; lsu_ready back 2 cycles after accept; mem_valid never asserted.
- Timeout: mem_valid high for exactly MEM_TIMEOUT cycles, then lsu_err for 1 cycle.
- mem_ready while mem_valid=0 is ignored.
- wb_rd, wb_data and lsu_err_* hold their values until the next DONE.

## Test plan
- lbu at 0x1003, mem_rdata=0x80FF_1234, zero-wait → wstrb=0, mem_addr=0x1000, wb_data=0x0000_0080, wb_valid 2 cycles after accept; lb same → 0xFFFF_FF80.
- sh at 0x2002, store_data_in=0xABCD_5678, mem_ready after 3 waits → wdata=0x5678_5678, wstrb=1100, mem_valid held 4 cycles, no wb_valid.
- lw at 0x3001 → lsu_err cause 01, lsu_err_addr=0x3001, mem_valid never high; sh at 0x3003 → cause 10.
- lw with mem_ready held 0, MEM_TIMEOUT=64 → mem_valid high exactly 64 cycles, then lsu_err cause 11, lsu_ready next cycle.
- lw rd=0 → bus completes, no wb_valid; ld_st_sel=0 with lsu_valid=1 → no acceptance, lsu_ready stays 1.
- rst_n low during BUS → mem_valid drops without a clock edge; after release, lsu_ready=1 and the next sw completes normally with wstrb=1111.
